// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture front end: pairs camera bytes into pixels, optionally
// decimates 2x in both axes, and streams them into the frame-buffer write port.
module ov7670_capture #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int DECIMATE = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overrun
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int SRC_W = (DECIMATE != 0) ? 2 * IMG_W : IMG_W;
  localparam int SRC_H = (DECIMATE != 0) ? 2 * IMG_H : IMG_H;
  localparam int XW    = $clog2(SRC_W + 1) + 1;
  localparam int YW    = $clog2(SRC_H + 1) + 1;
  // One spare address bit so the counter can sit exactly at TOTAL once full.
  localparam logic [ADDR_W:0] ADDR_END = (ADDR_W + 1)'(TOTAL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t          state, next_state;
  logic            frame_entry, frame_end;
  logic            phase;
  logic            href_d;
  logic [7:0]      hi;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [ADDR_W:0] addr;
  logic            keep;

  assign keep = (DECIMATE == 0) || (!x[0] && !y[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A frame only starts after a full vsync high->low, so a capture enabled
  // mid-frame never writes a partial image.
  always_comb begin
    next_state  = state;
    frame_entry = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (cam_vsync && capture_en) next_state = SYNC;
      end
      SYNC: begin
        if (!cam_vsync) begin
          next_state  = ACTIVE;
          frame_entry = 1'b1;
        end
      end
      ACTIVE: begin
        if (cam_vsync) begin
          frame_end  = 1'b1;
          next_state = capture_en ? SYNC : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      phase       <= 1'b0;
      href_d      <= 1'b0;
      hi          <= '0;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (frame_entry) begin
        addr    <= '0;
        x       <= '0;
        y       <= '0;
        phase   <= 1'b0;
        href_d  <= 1'b0;
        overrun <= 1'b0;
      end else if (frame_end) begin
        // vsync wins over a coincident href byte: that byte is dropped.
        frame_done  <= 1'b1;
        frame_count <= frame_count + 8'd1;
        phase       <= 1'b0;
        x           <= '0;
        href_d      <= 1'b0;
      end else if (state == ACTIVE) begin
        href_d <= cam_href;
        if (cam_href) begin
          phase <= ~phase;
          if (!phase) begin
            hi <= cam_data;
          end else begin
            x <= x + 1'b1;
            if (keep) begin
              if (addr == ADDR_END) begin
                overrun <= 1'b1;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= addr[ADDR_W-1:0];
                wr_data <= {hi, cam_data};
                addr    <= addr + 1'b1;
              end
            end
          end
        end else begin
          // Dropping phase here discards any dangling odd byte of the line.
          phase <= 1'b0;
          x     <= '0;
          if (href_d) y <= y + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Capture front end of the camera datapath; runs in the camera pixel-clock domain.
- Assembles OV7670 RGB565 byte pairs into 16-bit pixels, optionally decimates 640x480 to 320x240, and writes them into the 320x240 dual-port frame buffer.
- The VGA scan-out stage reads that buffer through its second port.
- Reports frame boundaries, a frame count and overrun errors.

Parameters:
- IMG_W, 320: stored image width in pixels.
- IMG_H, 240: stored image height in lines.
- DECIMATE, 1: 1 = source is 2*IMG_W x 2*IMG_H, keep only even columns of even lines; 0 = source is IMG_W x IMG_H, keep all pixels.
- ADDR_W, 17: frame-buffer address width. Must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  camera PCLK; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- capture_en  in  1  enable continuous capture; sampled only at frame boundaries
- cam_vsync  in  1  camera VSYNC; high = vertical blanking
- cam_href  in  1  camera HREF; high = valid bytes on cam_data
- cam_data  in  8  camera pixel byte
- wr_en  out  1  frame-buffer write strobe, one clk per pixel
- wr_addr  out  ADDR_W  frame-buffer write address
- wr_data  out  16  RGB565 pixel {R[4:0], G[5:0], B[4:0]}
- frame_done  out  1  one-clk pulse at the end of each captured frame
- frame_count  out  8  number of completed frames, wraps 255 -> 0
- overrun  out  1  sticky; source delivered more than IMG_W*IMG_H kept pixels this frame

Behaviour:
- Reset values: all outputs 0; state IDLE; byte phase 0; x/y counters 0.
- Inputs are sampled directly on clk; no synchronizers, because the block shares the camera clock.
- FSM:
  - IDLE: wait for cam_vsync=1 with capture_en=1 -> SYNC.
  - SYNC: wait for cam_vsync=0 -> ACTIVE. On entry to ACTIVE: addr=0, x=0, y=0, phase=0, overrun=0.
  - ACTIVE, cam_vsync rises (0->1):
    - frame_done=1 for one clk; frame_count+1.
    - Next state SYNC if capture_en=1, otherwise IDLE.
- Entering mid-frame: capture_en going high while cam_vsync=0 causes no writes until a full vsync high->low transition has been seen.
- Byte assembly (ACTIVE, cam_href=1):
  - phase 0: latch cam_data as high byte.
  - phase 1: form pixel {hi, cam_data}.
  - phase toggles every clk while href=1 and is forced to 0 while href=0.
  - A dangling odd byte at the href falling edge is discarded.
- Counters:
  - x = source pixel index within the line; increments per completed pixel; cleared when href=0.
  - y increments on each href falling edge; cleared on frame entry.
- Keep rule:
  - DECIMATE=1: keep the pixel iff x[0]=0 and y[0]=0.
  - DECIMATE=0: keep every pixel.
- Write timing:
  - A kept pixel asserts wr_en in the clk after its low byte is sampled, with wr_data = pixel and wr_addr = current address.
  - Address increments by 1 after each write.
  - Latency: low byte sampled at edge N -> wr_en high during cycle N+1.
- Overrun: when addr has reached IMG_W*IMG_H, further kept pixels are not written, addr holds at IMG_W*IMG_H, and overrun=1 until the next frame entry.
- Short frames: frame_done still pulses; remaining buffer locations are untouched.
- Simultaneous vsync rise and href=1: vsync wins. Frame ends, the partial pixel is dropped, and no write occurs in that clk.
- wr_addr/wr_data hold their last values when wr_en=0.
- Reset mid-frame: immediate return to IMG/reset values. The next write occurs only after a complete vsync cycle.

Test Plan:
- DECIMATE=0, IMG_W=4, IMG_H=2, capture_en=1; vsync pulse, then 2 lines of 8 bytes 0x00..0x0F.
  -> 8 writes, addr 0..7, data 0x0001, 0x0203, ..., 0x0E0F.
  -> frame_done pulses once on the vsync rise; frame_count=1.
- DECIMATE=1, IMG_W=4, IMG_H=2; source 8x4 with pixel value = {y, x}.
  -> writes only at (x,y) in {0,2,4,6}x{0,2}, addr 0..7 in order; exactly 8 wr_en pulses.
- DECIMATE=0, 4x2; send 3 lines.
  -> writes stop after addr 7; overrun=1.
  -> next frame: overrun clears on entry and addr restarts at 0.
- Odd byte test: line with 7 bytes.
  -> 3 writes; 7th byte dropped.
  -> next line starts at phase 0, so its first pixel = first two bytes.
- capture_en dropped mid-frame.
  -> the current frame completes with frame_done.
  -> FSM enters IDLE; no writes during the following frame.
- Assert reset during line 1, release, resume mid-frame.
  -> all outputs 0; no wr_en until after the next vsync high->low; addr restarts at 0.
